fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each requester word and of the FIFO write data.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, giving the maximum words written per grant.
REQ-004 wrclk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-005 clear_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 req  input  NUM_REQ  SHALL carry, per requester, "word available" for that requester.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  SHALL carry the requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ack  output  NUM_REQ  SHALL be one-hot or zero; ack[i]=1 means requester i's word was written on this edge.
REQ-009 grant  output  NUM_REQ  SHALL be the registered one-hot grant, or zero when idle.
REQ-010 data  output  DATA_WIDTH  SHALL drive the FIFO write data.
REQ-011 wrreq  output  1  SHALL drive the FIFO write request.
REQ-012 wrfull  input  1  SHALL be the FIFO full flag from the FIFO write port.
REQ-013 busy  output  1  SHALL be 1 whenever state is GRANT.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (grant=0) and GRANT (grant one-hot, registered).
REQ-015 In GRANT with grant[g]=1, wrreq SHALL equal req[g] & ~wrfull combinationally, with zero-cycle latency.
REQ-016 data SHALL equal req_data slice g while in GRANT; data SHALL be all-zero in IDLE.
REQ-017 ack SHALL equal grant when wrreq=1, and zero otherwise; a requester SHALL advance its word only on an edge where its ack=1.
REQ-018 A burst counter SHALL reset to 0 on each new grant and increment by 1 on each edge with wrreq=1; its width SHALL be enough to hold BURST_LEN.
REQ-019 wrfull=1 SHALL stall the transfer: no wrreq, no ack, counter held, and grant held with no timeout.
REQ-020 The grant SHALL release at an edge when either (a) the counter reaches BURST_LEN, including the write on that edge, or (b) req[g]=0 while wrfull=0.
REQ-021 Round-robin pointer rr SHALL point to the highest-priority requester; on release from requester g, rr SHALL become (g+1) mod NUM_REQ.
REQ-022 Arbitration SHALL select the first asserted req at or after rr, wrapping modulo NUM_REQ.
REQ-023 From IDLE, if any req=1, the next state SHALL be GRANT to the selected requester; otherwise the state SHALL stay IDLE.
REQ-024 On release, arbitration SHALL use the updated rr in the same edge, so GRANT goes directly to the next requester with no idle bubble.
REQ-025 If no req is asserted at release, the next state SHALL be IDLE.
REQ-026 A released requester that is still requesting SHALL be re-granted only if no other requester is asserted, since it wraps to lowest priority.
REQ-027 Simultaneous requests in IDLE SHALL be resolved by rr alone; with NUM_REQ requesters continuously requesting, each SHALL receive exactly one burst per NUM_REQ grants.
REQ-028 grant, rr, counter and state SHALL be registers; wrreq, ack and data SHALL be combinational from those registers plus req, req_data and wrfull.

Reset
REQ-029 While clear_n=0, the block SHALL hold state=IDLE, grant=0, rr=0, counter=0, busy=0, wrreq=0, ack=0 and data=0, independent of wrclk.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately; no further wrreq SHALL occur until at least one edge after clear_n rises.
REQ-031 The first grant after reset SHALL go to the lowest-index asserted requester.

Verification
REQ-032 Reset, then req=4'b0101 held with wrfull=0 -> grant 0001 for 4 edges with 4 acks, then grant 0100 for 4 edges with no idle cycle, then 0001 again.
REQ-033 Only req[2]=1 with 2 words, then req[2] deasserted -> 2 acks, grant released, state IDLE, rr=3.
REQ-034 Grant on requester 1 after 1 word; wrfull=1 for 5 cycles -> wrreq=0, ack=0, grant held at 0010, counter 1; after wrfull drops, exactly 3 more words are written.
REQ-035 rr=3 with req=4'b1001 at a release edge -> next grant 1000; after its burst, next grant 0001 (wrap-around).
REQ-036 clear_n pulsed low on the 2nd word of a burst -> grant=0 and wrreq=0 immediately; after release, req=4'b1111 -> grant 0001.
REQ-037 Bench SHALL check every cycle: ack is one-hot or zero, wrreq=0 whenever wrfull=1, and data equals the granted slice whenever wrreq=1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that gives one requester at a time a burst of up to
// BURST_LEN writes into a FIFO write port, stalling while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          wrclk,
    input  logic                          clear_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          wrreq,
    input  logic                          wrfull,
    output logic                          busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [PTR_W-1:0]   rr, rr_next, gidx;
    logic [CNT_W-1:0]   count, count_next;
    logic               req_granted;
    logic               release_now;
    int                 sel;

    // First asserted request at or after base, wrapping; -1 when none.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int base);
        int result;
        int j;
        result = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = base + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (r[j]) result = j;
        end
        return result;
    endfunction

    always_comb begin
        gidx = '0;
        data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx = PTR_W'(i);
                data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy        = (state == GRANT);
    assign req_granted = |(req & grant);
    assign wrreq       = busy & req_granted & ~wrfull;
    assign ack         = wrreq ? grant : '0;

    // Releasing and re-arbitrating happen on the same edge, so the next
    // requester is granted without an idle cycle in between.
    always_comb begin
        state_next  = state;
        grant_next  = grant;
        rr_next     = rr;
        count_next  = count;
        release_now = 1'b0;
        sel         = -1;
        case (state)
            IDLE: begin
                sel = pick(req, int'(rr));
            end
            GRANT: begin
                if (wrreq) count_next = count + 1'b1;
                release_now = (wrreq && count == CNT_W'(BURST_LEN - 1)) ||
                              (!req_granted && !wrfull);
                if (release_now) begin
                    rr_next = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    sel     = pick(req, int'(rr_next));
                end
            end
            default: ;
        endcase
        if (state == IDLE || release_now) begin
            count_next = '0;
            if (sel >= 0) begin
                state_next = GRANT;
                for (int i = 0; i < NUM_REQ; i++) grant_next[i] = (i == sel);
            end else begin
                state_next = IDLE;
                grant_next = '0;
            end
        end
    end

    always_ff @(posedge wrclk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            grant <= '0;
            rr    <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            rr    <= rr_next;
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester model plus a scoreboard of
// the words expected at the FIFO write port, in arbitration order.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic             wrclk;
    logic             clear_n;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    grant;
    logic [DW-1:0]    data;
    logic             wrreq;
    logic             wrfull;
    logic             busy;

    typedef struct packed {
        int            idx;
        logic [DW-1:0] word;
    } exp_t;

    exp_t sb[$];
    int   left[NR];
    int   seq[NR];
    int   exp_seq[NR];
    int   total_checks;
    int   passed_checks;
    int   failed_checks;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .wrclk(wrclk),
        .clear_n(clear_n),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .grant(grant),
        .data(data),
        .wrreq(wrreq),
        .wrfull(wrfull),
        .busy(busy)
    );

    initial begin
        wrclk = 1'b0;
        forever #5 wrclk = ~wrclk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] word_of(input int i, input int s);
        logic [DW-1:0] w;
        w = {i[1:0], s[5:0]};
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total_checks = total_checks + 1;
        assert (observed === expected) passed_checks = passed_checks + 1;
        else begin
            failed_checks = failed_checks + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive_requesters();
        for (int i = 0; i < NR; i++) begin
            req[i] = (left[i] > 0);
            req_data[i*DW +: DW] = word_of(i, seq[i]);
        end
    endtask

    task automatic expect_words(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{idx: i, word: word_of(i, exp_seq[i])});
            exp_seq[i] = exp_seq[i] + 1;
        end
    endtask

    // One clock: invariants and scoreboard at the falling edge, then the
    // requesters advance on whatever was acknowledged across the rising edge.
    task automatic apply_stimulus();
        logic [NR-1:0] acked;
        logic [NR-1:0] exp_ack;
        exp_t          e;
        @(negedge wrclk);
        check_output("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        check_output("ack_vs_grant", 32'(ack), 32'(wrreq ? grant : '0));
        if (wrfull) check_output("wrreq_when_full", 32'(wrreq), 32'd0);
        if (wrreq) begin
            check_output("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_ack = NR'(1 << e.idx);
                check_output("write_ack", 32'(ack), 32'(exp_ack));
                check_output("write_data", 32'(data), 32'(e.word));
                check_output("data_slice", 32'(data), 32'(req_data[e.idx*DW +: DW]));
            end
        end
        acked = ack;
        @(posedge wrclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acked[i]) begin
                seq[i]  = seq[i] + 1;
                left[i] = left[i] - 1;
            end
        end
        drive_requesters();
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        for (int i = 0; i < NR; i++) begin
            left[i]    = 0;
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        clear_n = 1'b0;
        wrfull  = 1'b0;
        drive_requesters();

        // Reset holds everything quiet even with all requesters asserted.
        #2;
        for (int i = 0; i < NR; i++) left[i] = 1;
        drive_requesters();
        #1;
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_wrreq", 32'(wrreq), 32'd0);
        check_output("rst_ack", 32'(ack), 32'd0);
        check_output("rst_data", 32'(data), 32'd0);
        check_output("rst_rr", 32'(dut.rr), 32'd0);
        check_output("rst_count", 32'(dut.count), 32'd0);
        for (int i = 0; i < NR; i++) left[i] = 0;
        drive_requesters();
        @(posedge wrclk);
        #2;
        clear_n = 1'b1;

        // Two requesters alternate full bursts with no idle bubble.
        left[0] = 8;
        left[2] = 4;
        expect_words(0, 4);
        expect_words(2, 4);
        expect_words(0, 4);
        drive_requesters();
        apply_stimulus();
        check_output("a_first_grant", 32'(grant), 32'b0001);
        check_output("a_busy", 32'(busy), 32'd1);
        repeat (3) apply_stimulus();
        check_output("a_mid_burst", 32'(grant), 32'b0001);
        apply_stimulus();
        check_output("a_no_bubble", 32'(grant), 32'b0100);
        repeat (4) apply_stimulus();
        check_output("a_back_to_0", 32'(grant), 32'b0001);
        repeat (4) apply_stimulus();
        check_output("a_sole_regrant", 32'(grant), 32'b0001);
        apply_stimulus();
        check_output("a_idle_grant", 32'(grant), 32'd0);
        check_output("a_idle_busy", 32'(busy), 32'd0);
        check_output("a_sb_drained", 32'(sb.size()), 32'd0);

        // Short request on requester 2 releases early and moves rr past it.
        left[2] = 2;
        expect_words(2, 2);
        drive_requesters();
        apply_stimulus();
        check_output("b_grant", 32'(grant), 32'b0100);
        repeat (3) apply_stimulus();
        check_output("b_idle_grant", 32'(grant), 32'd0);
        check_output("b_idle_busy", 32'(busy), 32'd0);
        check_output("b_rr", 32'(dut.rr), 32'd3);
        check_output("b_sb_drained", 32'(sb.size()), 32'd0);

        // rr=3 with requesters 3 and 0: priority wraps around.
        left[3] = 4;
        left[0] = 4;
        expect_words(3, 4);
        expect_words(0, 4);
        drive_requesters();
        apply_stimulus();
        check_output("c_grant3", 32'(grant), 32'b1000);
        repeat (4) apply_stimulus();
        check_output("c_wrap_grant0", 32'(grant), 32'b0001);
        repeat (5) apply_stimulus();
        check_output("c_idle", 32'(busy), 32'd0);
        check_output("c_sb_drained", 32'(sb.size()), 32'd0);

        // FIFO full stalls requester 1 after its first word.
        left[1] = 4;
        expect_words(1, 4);
        drive_requesters();
        apply_stimulus();
        check_output("d_grant", 32'(grant), 32'b0010);
        apply_stimulus();
        wrfull = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            check_output("d_stall_wrreq", 32'(wrreq), 32'd0);
            check_output("d_stall_ack", 32'(ack), 32'd0);
            apply_stimulus();
            check_output("d_stall_grant", 32'(grant), 32'b0010);
            check_output("d_stall_count", 32'(dut.count), 32'd1);
        end
        wrfull = 1'b0;
        #1;
        repeat (3) apply_stimulus();
        check_output("d_words_written", 32'(seq[1]), 32'd4);
        check_output("d_sb_drained", 32'(sb.size()), 32'd0);
        apply_stimulus();
        check_output("d_idle", 32'(busy), 32'd0);

        // Reset lands while the second word of a burst is on the port.
        left[3] = 4;
        expect_words(3, 1);
        drive_requesters();
        apply_stimulus();
        check_output("e_grant3", 32'(grant), 32'b1000);
        apply_stimulus();
        check_output("e_second_pending", 32'(wrreq), 32'd1);
        clear_n = 1'b0;
        #1;
        check_output("e_abort_grant", 32'(grant), 32'd0);
        check_output("e_abort_wrreq", 32'(wrreq), 32'd0);
        check_output("e_abort_ack", 32'(ack), 32'd0);
        check_output("e_abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NR; i++) left[i] = 4;
        drive_requesters();
        #1;
        check_output("e_rst_wrreq", 32'(wrreq), 32'd0);
        check_output("e_rst_data", 32'(data), 32'd0);
        clear_n = 1'b1;
        expect_words(0, 4);
        expect_words(1, 4);
        expect_words(2, 4);
        expect_words(3, 4);
        apply_stimulus();
        check_output("e_first_grant", 32'(grant), 32'b0001);
        for (int c = 0; c < 40 && sb.size() > 0; c++) apply_stimulus();
        check_output("e_rotation_done", 32'(sb.size()), 32'd0);
        for (int c = 0; c < 5 && busy; c++) apply_stimulus();
        check_output("e_final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
